// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and byte-lane merge helper for the data memory responder
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Replace only the byte lanes whose enable bit is set
  function automatic logic [WORD_W-1:0] be_merge(
    input logic [WORD_W-1:0] old,
    input logic [WORD_W-1:0] wdata,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// rtl/byte_en_ram.sv - word memory with byte-enabled synchronous write and combinational read
module byte_en_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] ram_memory [DEPTH];

  // Byte-lane write; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) ram_memory[waddr] <= be_merge(ram_memory[waddr], wdata, be);
  end

  assign rdata = ram_memory[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshaked load/store responder with fixed wait-state latency
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t            state, state_nxt;
  logic [3:0]        count;
  logic              ready_q;
  logic              cap_we, cap_err;
  logic [AW-1:0]     cap_idx;
  logic              accept;
  logic [29:0]       req_word;
  logic              req_bad;
  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     raddr;
  logic [WORD_W-1:0] rd_data;
  logic              sel_we, sel_err;
  logic              enter_resp;

  assign req_word = req_addr[31:2];
  assign req_bad  = (req_addr[1:0] != 2'b00) || (req_word >= 30'(DEPTH));
  assign req_idx  = req_word[AW-1:0];

  // ready_q is only ever 1 while in IDLE, so this also gates on state
  assign accept     = req_valid && ready_q;
  assign req_ready  = ready_q;
  assign resp_valid = (state == RESP);

  // With LATENCY==1 RESP is entered on the accept edge itself, before capture
  assign raddr      = (state == IDLE) ? req_idx : cap_idx;
  assign sel_we     = (state == IDLE) ? req_we  : cap_we;
  assign sel_err    = (state == IDLE) ? req_bad : cap_err;
  assign enter_resp = (state_nxt == RESP) && (state != RESP);

  byte_en_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept && req_we && !req_bad),
    .waddr (req_idx),
    .wdata (req_wdata),
    .be    (req_be),
    .raddr (raddr),
    .rdata (rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (count == 4'd1) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q    <= 1'b0;
      count      <= 4'd0;
      cap_we     <= 1'b0;
      cap_err    <= 1'b0;
      cap_idx    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        cap_we  <= req_we;
        cap_err <= req_bad;
        cap_idx <= req_idx;
        count   <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (enter_resp) begin
        resp_err   <= sel_err;
        resp_rdata <= (sel_err || sel_we) ? '0 : rd_data;
      end
    end
  end

endmodule
